// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: 4-stage signed pre-add / multiply / post-add slice with valid
// tagging, global stall, signed overflow detection and optional saturation.
module dsp_mac_pipe #(
   parameter int AW     = 18,
   parameter int BW     = 18,
   parameter int CW     = 48,
   parameter int PW     = 48,
   parameter bit SAT_EN = 1'b0
) (
   input  logic          clk,
   input  logic          rstN,
   input  logic          ce,
   input  logic          inValid,
   input  logic [4:0]    opMode,
   input  logic [AW-1:0] A,
   input  logic [BW-1:0] B,
   input  logic [BW-1:0] D,
   input  logic [CW-1:0] C,
   input  logic          carryIn,
   input  logic [PW-1:0] PCIn,
   output logic [BW-1:0] BCOut,
   output logic [AW+BW:0] M,
   output logic [PW-1:0] P,
   output logic [PW-1:0] PCOut,
   output logic          carryOut,
   output logic          overflow,
   output logic          outValid
);
   localparam int MW  = AW + BW + 1;
   localparam int PRW = BW + 1;

   logic signed [AW-1:0]  a1_q, a2_q;
   logic signed [BW-1:0]  b1_q, d1_q;
   logic signed [CW-1:0]  c1_q, c2_q, c3_q;
   logic signed [PRW-1:0] pre2_q, pre2_d;
   logic signed [MW-1:0]  m_q, m_d;
   logic [4:0]            op1_q;
   logic [2:0]            op2_q, op3_q;
   logic                  cin1_q, cin2_q, cin3_q;
   logic                  vld1_q, vld2_q, vld3_q;
   logic [PW-1:0]         p_q, p_d, z, mx;
   logic [PW:0]           s;
   logic                  co_q, co_d, ov_q, ov_d, out_vld_q;

   always_comb begin
      pre2_d = !op1_q[1] ? PRW'(b1_q)
             : op1_q[0]  ? PRW'(d1_q) - PRW'(b1_q)
             :             PRW'(d1_q) + PRW'(b1_q);
      m_d    = MW'(a2_q) * MW'(pre2_q);
      mx     = PW'(m_q);
      z      = op3_q[1:0] == 2'b00 ? '0
             : op3_q[1:0] == 2'b01 ? p_q
             : op3_q[1:0] == 2'b10 ? PW'(c3_q)
             :                       PCIn;
      s      = op3_q[2] ? {1'b0, z} - {1'b0, mx} - {{PW{1'b0}}, cin3_q}
             :            {1'b0, z} + {1'b0, mx} + {{PW{1'b0}}, cin3_q};
      co_d   = s[PW];
      ov_d   = (op3_q[2] ? z[PW-1] != mx[PW-1] : z[PW-1] == mx[PW-1]) && s[PW-1] != z[PW-1];
      // Overflow direction follows the sign of Z: a positive Z can only overflow upward.
      p_d    = SAT_EN && ov_d ? (z[PW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}})
             :                  s[PW-1:0];
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         a1_q      <= '0;
         b1_q      <= '0;
         d1_q      <= '0;
         c1_q      <= '0;
         op1_q     <= '0;
         cin1_q    <= 1'b0;
         vld1_q    <= 1'b0;
         a2_q      <= '0;
         pre2_q    <= '0;
         c2_q      <= '0;
         op2_q     <= '0;
         cin2_q    <= 1'b0;
         vld2_q    <= 1'b0;
         m_q       <= '0;
         c3_q      <= '0;
         op3_q     <= '0;
         cin3_q    <= 1'b0;
         vld3_q    <= 1'b0;
         p_q       <= '0;
         co_q      <= 1'b0;
         ov_q      <= 1'b0;
         out_vld_q <= 1'b0;
      end else begin
         out_vld_q <= ce & vld3_q;
         if (ce) begin
            a1_q   <= A;
            b1_q   <= B;
            d1_q   <= D;
            c1_q   <= C;
            op1_q  <= opMode;
            cin1_q <= carryIn;
            vld1_q <= inValid;
            a2_q   <= a1_q;
            pre2_q <= pre2_d;
            c2_q   <= c1_q;
            op2_q  <= op1_q[4:2];
            cin2_q <= cin1_q;
            vld2_q <= vld1_q;
            m_q    <= m_d;
            c3_q   <= c2_q;
            op3_q  <= op2_q;
            cin3_q <= cin2_q;
            vld3_q <= vld2_q;
            if (vld3_q) begin
               p_q  <= p_d;
               co_q <= co_d;
               ov_q <= ov_d;
            end
         end
      end
   end

   assign BCOut    = b1_q;
   assign M        = m_q;
   assign P        = p_q;
   assign PCOut    = p_q;
   assign carryOut = co_q;
   assign overflow = ov_q;
   assign outValid = out_vld_q;
endmodule

// File: doc/dsp_mac_pipe.md
# dsp_mac_pipe

Parametrised, fully pipelined signed multiply-accumulate slice. It is the next-generation DSP slice for this codebase. Relative to the fixed-width 18x18/48 slice it adds parameter-set operand widths, a valid-tagged pipeline with a global stall, signed overflow detection and optional saturation. Chains through `BCOut`/`PCOut` like the existing slice and feeds filter and accumulator datapaths.

## Interface
- `AW`, 18: width of `A`, signed.
- `BW`, 18: width of `B` and `D`, signed.
- `CW`, 48: width of `C`, signed. Constraint: `CW <= PW`.
- `PW`, 48: width of `P`/`PCIn`/`PCOut`. Constraint: `PW >= AW+BW+1`.
- `SAT_EN`, 0: 1 = clamp `P` on signed overflow; 0 = wrap.
- `clk` in 1: rising-edge clock.
- `rstN` in 1: reset, asynchronous, active-low; clears every register.
- `ce` in 1: global clock enable; 0 = stall.
- `inValid` in 1: input operands valid this cycle.
- `opMode` in 5: `[0]` preSub (0: D+B, 1: D−B); `[1]` usePre (1: mult input = pre-adder, 0: B); `[3:2]` zSel (00: 0, 01: P feedback, 10: C, 11: PCIn); `[4]` postSub.
- `A` in AW: multiplier operand.
- `B` in BW: pre-adder/multiplier operand.
- `D` in BW: pre-adder operand.
- `C` in CW: post-adder operand, sign-extended to PW.
- `carryIn` in 1: post-adder carry/borrow in.
- `PCIn` in PW: cascade input, sampled at stage 3 (no input register).
- `BCOut` out BW: stage-1 B register.
- `M` out AW+BW+1: stage-3 product register.
- `P` out PW: result register.
- `PCOut` out PW: identical to `P`.
- `carryOut` out 1: carry/borrow of the post-add, registered with `P`.
- `overflow` out 1: signed overflow of the result now on `P` (per-result, not sticky).
- `outValid` out 1: `P`/`carryOut`/`overflow` hold a new result this cycle.

## Operation
- Stage 1 (input): when `ce`=1, register `A`, `B`, `D`, `C`, `carryIn`, `opMode` and `vld1` <= `inValid`.
- Stage 2 (pre-add): pre = `usePre` ? (`preSub` ? D−B : D+B) : B, computed at BW+1 bits, sign-extended. Register pre, A and delayed controls; `vld2` <= `vld1`.
- Stage 3 (multiply): `M` <= A × pre, full-precision signed (AW+BW+1 bits); `vld3` <= `vld2`.
- Stage 4 (post-add). Mx = `M` sign-extended to PW. Z selected by zSel from 0, current `P`, delayed C, or `PCIn`.
  - Add: {`carryOut`, sum} = {0,Z} + {0,Mx} + cin.
  - Sub: {`carryOut`, sum} = {0,Z} − {0,Mx} − cin. `carryOut`=1 means borrow.
- `overflow` = signed overflow of sum: operand signs equal (add) or differ (sub) and the result sign differs from Z.
- Saturation: if `SAT_EN`=1 and overflow, `P` <= 2^(PW−1)−1 on positive overflow, −2^(PW−1) on negative overflow. Otherwise `P` <= sum. `overflow` is reported in both modes.
- `P`, `carryOut` and `overflow` update only when `ce`=1 and `vld3`=1; otherwise they hold.
- P-feedback uses the current `P`, so back-to-back zSel=01 issues accumulate every cycle.
- Bubbles (`inValid`=0) travel as invalid and never modify `P`.

## Timing
- Latency 4: an operand set accepted at edge n (`ce`=1, `inValid`=1) appears on `P` with `outValid`=1 after edge n+3. Throughput 1 per cycle.
- `BCOut` valid 1 cycle after the sample; `M` valid 3 cycles after the sample.
- Stall: while `ce`=0, stages 1–3, `P`, `carryOut` and `overflow` hold. `outValid` is loaded with 0, so each result pulses exactly once; no duplicates and no loss.
- `outValid` <= `ce` & `vld3` on every edge.
- Reset: `rstN` low asynchronously forces all outputs and valids to 0, mid-stream included. In-flight data is discarded. The first valid result after release needs the full 4-cycle latency.
- Changing `opMode` between issues is legal; each operand set carries its own `opMode` down the pipe.

## Test plan
- Reset: random inputs, `rstN`=0 → `P`, `PCOut`, `M`, `BCOut`, `carryOut`, `overflow`, `outValid` all 0. Asserting `rstN`=0 mid-stream clears everything within the same cycle.
- Pre-add path, defaults: A=20, B=10, D=25, opMode=00010 (usePre, D+B, Z=0, add), cin=0.
  - Required: `BCOut`=10 one cycle later; `M`=700 after three; `P`=700 with a single `outValid` pulse after four.
- Accumulate: clear `P`, then 5 consecutive issues of A=3, B=4, opMode=00100 → `P` = 12, 24, 36, 48, 60 on consecutive cycles, `outValid` high 5 cycles.
- Subtract/borrow: A=5, B=6, C=10, opMode=11000, cin=0.
  - Required: `P`=0xFFFF_FFFF_FFEC (−20), `carryOut`=1, `overflow`=0.
  - With C=350: `P`=320, `carryOut`=0.
- Overflow: PCIn=0x7FFF_FFFF_FFFF, A=1, B=1, opMode=01100.
  - SAT_EN=0: `P`=0x8000_0000_0000, `overflow`=1.
  - SAT_EN=1: `P`=0x7FFF_FFFF_FFFF, `overflow`=1.
- Stall: stream 4 distinct products and drop `ce` for 2 cycles mid-stream → all 4 results appear in order, each `outValid` pulse exactly once, 2 cycles later than unstalled.
